// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence generator and detectors.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    // Generator control states, 2-bit encoding shared with debug views.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } gen_state_t;

    // Reference pattern that the 1001 detectors look for.
    localparam logic [3:0] PAT_1001 = 4'b1001;

    // Default widths for the pattern and the repeat/gap fields.
    localparam int SEQ_PAT_W = 4;
    localparam int SEQ_CNT_W = 8;

    // Width needed to index a pattern of pat_w bits (at least 1).
    function automatic int idx_width(input int pat_w);
        return (pat_w > 1) ? $clog2(pat_w) : 1;
    endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control/status bundle between a pattern generator and its controller.
// Latency: n/a (wires only).
// Backpressure: none; the generator ignores start while busy.
interface seq_pattern_gen_if
    import seq_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W,
    parameter int CNT_W = SEQ_CNT_W
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeats;
    logic [CNT_W-1:0] gap;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    // Controller side: issues jobs, watches the serial stream and status.
    modport master (
        output start, abort, pattern, repeats, gap,
        input  dout, dout_valid, busy, done
    );

    // Generator side.
    modport slave (
        input  start, abort, pattern, repeats, gap,
        output dout, dout_valid, busy, done
    );
endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
// Latency: count updates one clock after load/dec; zero flag follows the register.
// Backpressure: none; clear beats load beats decrement.
module seq_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, then load, then a saturating decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern MSB-first, N times, with optional gaps.
// Latency: first bit one clock after an accepted start; done one clock after the last bit.
// Backpressure: none; start is ignored while busy, abort forces IDLE next clock.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    seq_pattern_gen_if.slave bus
);
    localparam int IDX_W = idx_width(PAT_W);

    gen_state_t       state_q;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] gap_q;
    logic             dout_q;
    logic             vld_q;
    logic             busy_q;
    logic             done_q;

    logic [IDX_W-1:0] idx_cnt;
    logic             idx_zero;
    logic [CNT_W-1:0] gap_cnt;
    logic             gap_zero;
    logic [CNT_W-1:0] rep_cnt;
    logic             rep_zero;

    logic             accept;
    logic             idx_last;
    logic             rep_last;
    logic             gap_end;
    logic             idx_load;
    logic             idx_dec;
    logic             gap_load;
    logic             gap_dec;
    logic             rep_load;
    logic             rep_dec;
    logic             unused_cnt;

    // Decode the transitions that steer the three counters.
    always_comb begin
        accept   = bus.start && !bus.abort && ((state_q == IDLE) || (state_q == DONE));
        idx_last = (state_q == SHIFT) && idx_zero;
        rep_last = (rep_cnt == CNT_W'(1));
        gap_end  = (state_q == GAP) && gap_zero;
        // Bit index restarts on a new job, on a contiguous repeat, or leaving a gap.
        idx_load = accept || (idx_last && !rep_last && (gap_q == '0)) || gap_end;
        idx_dec  = (state_q == SHIFT) && !idx_zero;
        // Gap counter is loaded with gap-1 so that zero marks the final gap cycle.
        gap_load = idx_last && !rep_last && (gap_q != '0);
        gap_dec  = (state_q == GAP) && !gap_zero;
        rep_load = accept;
        // Exit test (rep_last) comes first, so the repeat count never wraps.
        rep_dec  = idx_last && !rep_last;
    end

    seq_down_counter #(.W(IDX_W)) u_idx_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (bus.abort),
        .load_i     (idx_load),
        .load_val_i (IDX_W'(PAT_W - 1)),
        .dec_i      (idx_dec),
        .cnt_o      (idx_cnt),
        .zero_o     (idx_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_gap_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (bus.abort),
        .load_i     (gap_load),
        .load_val_i (gap_q - CNT_W'(1)),
        .dec_i      (gap_dec),
        .cnt_o      (gap_cnt),
        .zero_o     (gap_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_rep_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (bus.abort),
        .load_i     (rep_load),
        .load_val_i (bus.repeats),
        .dec_i      (rep_dec),
        .cnt_o      (rep_cnt),
        .zero_o     (rep_zero)
    );

    // Only the zero flag of the gap counter and the value of the repeat counter steer control.
    assign unused_cnt = ^{gap_cnt, rep_zero};

    // Control FSM with registered outputs; outputs describe the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            gap_q   <= '0;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.abort) begin
            state_q <= IDLE;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    dout_q  <= 1'b0;
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        pat_q <= bus.pattern;
                        gap_q <= bus.gap;
                        if (bus.repeats == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                            dout_q  <= bus.pattern[PAT_W-1];
                            vld_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (!idx_zero) begin
                        dout_q <= pat_q[idx_cnt - IDX_W'(1)];
                    end else if (rep_last) begin
                        state_q <= DONE;
                        dout_q  <= 1'b0;
                        vld_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (gap_q != '0) begin
                        state_q <= GAP;
                        dout_q  <= 1'b0;
                        vld_q   <= 1'b0;
                    end else begin
                        dout_q <= pat_q[PAT_W-1];
                    end
                end
                GAP: begin
                    if (gap_zero) begin
                        state_q <= SHIFT;
                        dout_q  <= pat_q[PAT_W-1];
                        vld_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    dout_q  <= 1'b0;
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen against a per-cycle stream model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_seq_pattern_gen;
    import seq_pkg::*;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    // Observation word: {dout, dout_valid, busy, done}
    typedef logic [3:0] obs_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    obs_t exp_q[$];

    seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        return {bus.dout, bus.dout_valid, bus.busy, bus.done};
    endfunction

    // Expected per-cycle outputs of one job, starting the cycle after start is sampled.
    function automatic void model_job(input logic [PAT_W-1:0] pat, input int reps, input int gp);
        for (int r = 0; r < reps; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
            if (r < reps - 1) begin
                for (int g = 0; g < gp; g++) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0001);
    endfunction

    task automatic launch(input logic [PAT_W-1:0] pat, input int reps, input int gp);
        bus.start   = 1'b1;
        bus.abort   = 1'b0;
        bus.pattern = pat;
        bus.repeats = CNT_W'(reps);
        bus.gap     = CNT_W'(gp);
    endtask

    task automatic scramble();
        bus.start   = 1'b0;
        bus.pattern = PAT_W'($urandom);
        bus.repeats = CNT_W'($urandom);
        bus.gap     = CNT_W'($urandom);
    endtask

    task automatic test_reset();
        obs_t obs;
        bus.start = 1'b1; bus.abort = 1'b0;
        bus.pattern = PAT_1001; bus.repeats = 8'd3; bus.gap = 8'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            obs = observe();
            n_checks++;
            if (obs !== 4'b0000) begin
                n_errors++;
                $display("FAIL reset_hold cycle %0d: got %b want 0000", k, obs);
            end
        end
        bus.start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        obs = observe();
        n_checks++;
        if (obs !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_release: got %b want 0000", obs);
        end
    endtask

    task automatic test_single();
        obs_t obs;
        logic [PAT_W-1:0] bits;
        logic [PAT_W-1:0] want_bits;
        want_bits = PAT_1001;
        bits = '0;
        exp_q.delete();
        model_job(PAT_1001, 1, 0);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        launch(PAT_1001, 1, 0);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            obs = observe();
            scramble();
            if (k <= PAT_W) bits = {bits[PAT_W-2:0], obs[3]};
            n_checks++;
            if (obs !== exp_q[k-1]) begin
                n_errors++;
                $display("FAIL single T+%0d: got %b want %b", k, obs, exp_q[k-1]);
            end
        end
        n_checks++;
        if (bits !== want_bits) begin
            n_errors++;
            $display("FAIL single_bits: got %b want %b", bits, want_bits);
        end
    endtask

    task automatic test_back_to_back();
        obs_t obs;
        logic [11:0] bits;
        logic [11:0] want_bits;
        int hits;
        want_bits = 12'b1001_1001_1001;
        bits = '0;
        hits = 0;
        exp_q.delete();
        model_job(PAT_1001, 3, 0);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        launch(PAT_1001, 3, 0);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            obs = observe();
            scramble();
            if (k <= 12) begin
                bits = {bits[10:0], obs[3]};
                if (k >= 4 && bits[3:0] == 4'b1001) hits++;
            end
            n_checks++;
            if (obs !== exp_q[k-1]) begin
                n_errors++;
                $display("FAIL b2b T+%0d: got %b want %b", k, obs, exp_q[k-1]);
            end
        end
        n_checks++;
        if (bits !== want_bits || hits != 3) begin
            n_errors++;
            $display("FAIL b2b_stream: got %b hits %0d want %b hits 3", bits, hits, want_bits);
        end
    endtask

    task automatic test_gapped();
        obs_t obs;
        int cfg_reps[3] = '{2, 3, 2};
        int cfg_gap[3]  = '{2, 1, 255};
        for (int c = 0; c < 3; c++) begin
            exp_q.delete();
            model_job(PAT_1001, cfg_reps[c], cfg_gap[c]);
            exp_q.push_back(4'b0000);
            @(negedge clk);
            launch(PAT_1001, cfg_reps[c], cfg_gap[c]);
            for (int k = 1; k <= exp_q.size(); k++) begin
                @(negedge clk);
                obs = observe();
                scramble();
                n_checks++;
                if (obs !== exp_q[k-1]) begin
                    n_errors++;
                    $display("FAIL gapped cfg%0d T+%0d: got %b want %b", c, k, obs, exp_q[k-1]);
                end
            end
        end
    endtask

    task automatic test_zero_repeats();
        obs_t obs;
        exp_q.delete();
        model_job(4'b0110, 0, 3);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        launch(4'b0110, 0, 3);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            obs = observe();
            scramble();
            n_checks++;
            if (obs !== exp_q[k-1]) begin
                n_errors++;
                $display("FAIL zero_reps T+%0d: got %b want %b", k, obs, exp_q[k-1]);
            end
        end
    endtask

    task automatic test_max_repeats();
        obs_t obs;
        exp_q.delete();
        model_job(4'b1101, 255, 0);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        launch(4'b1101, 255, 0);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            obs = observe();
            scramble();
            n_checks++;
            if (obs !== exp_q[k-1]) begin
                n_errors++;
                $display("FAIL max_reps T+%0d: got %b want %b", k, obs, exp_q[k-1]);
            end
        end
    endtask

    task automatic test_start_collision();
        obs_t obs;
        exp_q.delete();
        model_job(PAT_1001, 2, 1);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        launch(PAT_1001, 2, 1);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            obs = observe();
            scramble();
            if (k == 2 || k == 5) launch(4'b0110, 7, 0);
            n_checks++;
            if (obs !== exp_q[k-1]) begin
                n_errors++;
                $display("FAIL start_busy T+%0d: got %b want %b", k, obs, exp_q[k-1]);
            end
        end
    endtask

    task automatic test_done_restart();
        obs_t obs;
        int done_k;
        exp_q.delete();
        model_job(4'b1011, 2, 0);
        done_k = exp_q.size();
        model_job(4'b0101, 1, 0);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        launch(4'b1011, 2, 0);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            obs = observe();
            scramble();
            if (k == done_k) launch(4'b0101, 1, 0);
            n_checks++;
            if (obs !== exp_q[k-1]) begin
                n_errors++;
                $display("FAIL done_restart T+%0d: got %b want %b", k, obs, exp_q[k-1]);
            end
        end
    endtask

    task automatic test_abort();
        obs_t obs;
        exp_q.delete();
        model_job(4'b1110, 3, 1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                launch(4'b1110, 3, 1);
                continue;
            end
            obs = observe();
            scramble();
            bus.abort = (k == 4) || (k == 12);
            if (k == 12) bus.start = 1'b1;
            n_checks++;
            if (k <= 4) begin
                if (obs !== exp_q[k-2]) begin
                    n_errors++;
                    $display("FAIL abort_pre T+%0d: got %b want %b", k - 1, obs, exp_q[k-2]);
                end
            end else if (obs !== 4'b0000) begin
                n_errors++;
                $display("FAIL abort_post T+%0d: got %b want 0000", k - 1, obs);
            end
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        obs_t obs;
        exp_q.delete();
        model_job(PAT_1001, 5, 0);
        @(negedge clk);
        launch(PAT_1001, 5, 0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            obs = observe();
            scramble();
            n_checks++;
            if (obs !== exp_q[k-1]) begin
                n_errors++;
                $display("FAIL reset_mid_pre T+%0d: got %b want %b", k, obs, exp_q[k-1]);
            end
        end
        #2 reset_n = 1'b0;
        #1 obs = observe();
        n_checks++;
        if (obs !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_mid_async: got %b want 0000", obs);
        end
        @(negedge clk);
        obs = observe();
        n_checks++;
        if (obs !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_mid_hold: got %b want 0000", obs);
        end
        reset_n = 1'b1;
        test_single();
    endtask

    task automatic test_random();
        obs_t obs;
        logic [PAT_W-1:0] pat;
        int reps;
        int gp;
        for (int j = 0; j < 30; j++) begin
            pat  = PAT_W'($urandom);
            reps = $urandom_range(0, 4);
            gp   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3);
            exp_q.delete();
            model_job(pat, reps, gp);
            exp_q.push_back(4'b0000);
            @(negedge clk);
            launch(pat, reps, gp);
            for (int k = 1; k <= exp_q.size(); k++) begin
                @(negedge clk);
                obs = observe();
                scramble();
                bus.start = exp_q[k-1][1] && ($urandom_range(0, 2) == 0);
                n_checks++;
                if (obs !== exp_q[k-1]) begin
                    n_errors++;
                    $display("FAIL random job%0d pat=%b reps=%0d gap=%0d T+%0d: got %b want %b",
                             j, pat, reps, gp, k, obs, exp_q[k-1]);
                end
            end
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.pattern = '0;
        bus.repeats = '0;
        bus.gap     = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gapped();
        test_zero_repeats();
        test_max_repeats();
        test_start_collision();
        test_done_restart();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern transmitter: on a start pulse it shifts a programmable PAT_W-bit pattern out MSB-first, one bit per clock, a programmable number of times, with an optional idle gap between repetitions. It is the source side of the serial sequence detectors. Its dout/dout_valid pair drives a detector's serial input in both system stimulus and loop-back self-test. With the default 4'b1001 pattern and zero gap, it produces the back-to-back overlapping streams that a 1001 Mealy detector must count.

## Interface
- PAT_W, default 4: pattern length in bits (≥2).
- CNT_W, default 8: width of the repeat and gap fields.
- clk  in  1: single clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- start  in  1: one-cycle request. Honoured only in IDLE or DONE.
- abort  in  1: synchronous stop. Returns to IDLE with no done pulse.
- pattern  in  PAT_W: bits to send, sampled on an accepted start.
- repeats  in  CNT_W: number of pattern transmissions. 0 is legal.
- gap  in  CNT_W: idle cycles between consecutive repetitions.
- dout  out  1: serial data. Registered; 0 whenever dout_valid=0.
- dout_valid  out  1: dout carries a pattern bit this cycle.
- busy  out  1: high in SHIFT and GAP.
- done  out  1: one-cycle pulse after the final bit.

## Operation
- States:
  - IDLE: outputs low.
  - SHIFT: driving pattern bits.
  - GAP: dout=0, dout_valid=0, busy=1.
  - DONE: done=1, busy=0; lasts exactly 1 cycle, then IDLE.
- Accepted start latches pattern, repeats and gap into internal registers. Inputs may change afterwards without effect.
- Start with repeats≠0 → SHIFT, with bit index = PAT_W-1.
- Start with repeats=0 → DONE directly. No bits are sent.
- SHIFT transitions:
  - Each cycle drives pattern[idx] and decrements idx.
  - At idx=0 with remaining repeats>1 and gap≠0 → GAP.
  - At idx=0 with remaining repeats>1 and gap=0 → reload idx and stay in SHIFT. The repetitions are contiguous and overlap-compatible.
  - At idx=0 with remaining repeats=1 → DONE.
- GAP: holds for exactly gap cycles, then reloads idx and goes to SHIFT.
- Remaining-repeat counter decrements once per completed pattern. Unsigned arithmetic with no wrap: the exit test happens before the decrement.
- start while busy is ignored. No queueing.
- start in DONE is accepted; DONE behaves as IDLE for acceptance.
- Abort in any state → IDLE next cycle:
  - all outputs low next cycle;
  - done not pulsed;
  - abort has priority over start in the same cycle.
- reset_n low at any time, including mid-pattern:
  - immediately clears state to IDLE;
  - clears all counters;
  - dout, dout_valid, busy and done go to 0.

## Timing
- All outputs are registered. Reset values: dout=0, dout_valid=0, busy=0, done=0.
- Start sampled high at edge T (state IDLE) → first bit, pattern[PAT_W-1], valid at T+1; busy=1 from T+1.
- One repetition occupies PAT_W cycles. Total active length = repeats·PAT_W + (repeats−1)·gap cycles.
- done is high in the single cycle after the last valid bit. busy is 0 in that cycle.
- repeats=0: done at T+1, with dout_valid never asserted.
- Earliest restart: a start in the DONE cycle produces its first bit the following cycle. This gives zero dead cycles between jobs other than DONE.

## Structure
- Shared package seq_pkg holds:
  - the gen_state_t enum (IDLE, SHIFT, GAP, DONE), 2-bit encoding;
  - constant PAT_1001 = 4'b1001, shared with the detectors;
  - default widths.
- One natural sub-module: seq_down_counter, a loadable down-counter with zero flag. It is instantiated for the bit index, the gap and the remaining repeats.
- Everything else stays inline in seq_pattern_gen.

## Test plan
- Single pattern: pattern=1001, repeats=1, gap=0, start at T → dout 1,0,0,1 at T+1..T+4 with dout_valid high; done at T+5; busy low at T+5.
- Back-to-back: repeats=3, gap=0 → stream 100110011001 on T+1..T+12 with valid continuous; done at T+13. A looped 1001 overlapping detector flags 3 hits.
- Gapped: repeats=2, gap=2 → 1001, then 2 cycles with valid=0 and dout=0, then 1001; done at T+11.
- Zero repeats: repeats=0 → done at T+1, dout_valid never high, busy never high.
- Collisions:
  - start pulsed at T+2 of a running job is ignored; stream unchanged.
  - start in the DONE cycle launches a new job, first bit next cycle.
  - abort at T+3 → all outputs 0 at T+4, no done.
- Reset mid-stream: reset_n low asynchronously during SHIFT → outputs 0 without waiting for a clock. After release, a new start behaves exactly as the single-pattern case.
